// File: rtl/accel_host_dma.sv
// accel_host_dma: host-side bus initiator that copies a programmed run of 32-bit words from a
// source address to a destination address. Define ACCEL_DMA_POLL_EN to poll a status word before each write.
module accel_host_dma #(
  parameter int BusWidth   = 32,
  parameter int CountWidth = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [BusWidth-1:0]     src_addr_i,
  input  logic [BusWidth-1:0]     dst_addr_i,
  input  logic [CountWidth-1:0]   len_i,
  input  logic                    src_inc_i,
  input  logic                    dst_inc_i,
  input  logic [BusWidth-1:0]     poll_addr_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [CountWidth-1:0]   words_done_o,
  output logic                    host_req_o,
  output logic [BusWidth-1:0]     host_addr_o,
  output logic                    host_we_o,
  output logic [BusWidth/8-1:0]   host_be_o,
  output logic [BusWidth-1:0]     host_wdata_o,
  input  logic                    host_gnt_i,
  input  logic                    host_rvalid_i,
  input  logic [BusWidth-1:0]     host_rdata_i,
  input  logic                    host_err_i
);

  localparam logic [BusWidth-1:0] WordStep = BusWidth'(4);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    FIN
`ifdef ACCEL_DMA_POLL_EN
    ,
    POLL,
    POLL_WAIT
`endif
  } state_t;

  function automatic logic [BusWidth-1:0] word_align(input logic [BusWidth-1:0] a);
    return {a[BusWidth-1:2], 2'b00};
  endfunction

  state_t                  state_q, state_d;
  logic [BusWidth-1:0]     src_q, src_d, dst_q, dst_d;
  logic [CountWidth-1:0]   len_q, len_d;
  logic                    src_inc_q, src_inc_d, dst_inc_q, dst_inc_d;
  logic                    err_q, err_d;
  logic [CountWidth-1:0]   words_q, words_d;
  logic                    req_q, req_d;
  logic                    we_q, we_d;
  logic [BusWidth/8-1:0]   be_q, be_d;
  logic [BusWidth-1:0]     addr_q, addr_d;
  logic [BusWidth-1:0]     wdata_q, wdata_d;

  logic [CountWidth-1:0]   words_inc;
  logic [BusWidth-1:0]     src_next, dst_next;

  // Address arithmetic wraps naturally at 2^32.
  assign words_inc = words_q + CountWidth'(1);
  assign src_next  = src_inc_q ? src_q + WordStep : src_q;
  assign dst_next  = dst_inc_q ? dst_q + WordStep : dst_q;

`ifdef ACCEL_DMA_POLL_EN
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{src_addr_i[1:0], dst_addr_i[1:0], poll_addr_i[1:0]};
`else
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{src_addr_i[1:0], dst_addr_i[1:0], poll_addr_i};
`endif

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    src_inc_d = src_inc_q;
    dst_inc_d = dst_inc_q;
    err_d     = err_q;
    words_d   = words_q;
    req_d     = req_q;
    we_d      = we_q;
    be_d      = be_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          src_d     = word_align(src_addr_i);
          dst_d     = word_align(dst_addr_i);
          len_d     = len_i;
          src_inc_d = src_inc_i;
          dst_inc_d = dst_inc_i;
          err_d     = 1'b0;
          words_d   = '0;
          if (len_i != '0) begin
            state_d = RD_REQ;
            req_d   = 1'b1;
            we_d    = 1'b0;
            be_d    = '1;
            addr_d  = word_align(src_addr_i);
          end else begin
            state_d = FIN;
          end
        end
      end
      RD_REQ: begin
        if (host_gnt_i) begin
          state_d = RD_WAIT;
          req_d   = 1'b0;
          be_d    = '0;
        end
      end
      RD_WAIT: begin
        // host_wdata_o doubles as the captured-word register.
        if (host_rvalid_i) begin
          wdata_d = host_rdata_i;
          if (host_err_i) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else begin
`ifdef ACCEL_DMA_POLL_EN
            state_d = POLL;
            req_d   = 1'b1;
            we_d    = 1'b0;
            be_d    = '1;
            addr_d  = word_align(poll_addr_i);
`else
            state_d = WR_REQ;
            req_d   = 1'b1;
            we_d    = 1'b1;
            be_d    = '1;
            addr_d  = dst_q;
`endif
          end
        end
      end
`ifdef ACCEL_DMA_POLL_EN
      POLL: begin
        if (host_gnt_i) begin
          state_d = POLL_WAIT;
          req_d   = 1'b0;
          be_d    = '0;
        end
      end
      POLL_WAIT: begin
        // Accelerator signals readiness for the next word through status bit 0.
        if (host_rvalid_i) begin
          if (host_err_i) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else if (host_rdata_i[0]) begin
            state_d = WR_REQ;
            req_d   = 1'b1;
            we_d    = 1'b1;
            be_d    = '1;
            addr_d  = dst_q;
          end else begin
            state_d = POLL;
            req_d   = 1'b1;
            we_d    = 1'b0;
            be_d    = '1;
            addr_d  = word_align(poll_addr_i);
          end
        end
      end
`endif
      WR_REQ: begin
        if (host_gnt_i) begin
          state_d = WR_WAIT;
          req_d   = 1'b0;
          be_d    = '0;
        end
      end
      WR_WAIT: begin
        if (host_rvalid_i) begin
          if (host_err_i) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else begin
            words_d = words_inc;
            src_d   = src_next;
            dst_d   = dst_next;
            if (words_inc == len_q) begin
              state_d = FIN;
            end else begin
              state_d = RD_REQ;
              req_d   = 1'b1;
              we_d    = 1'b0;
              be_d    = '1;
              addr_d  = src_next;
            end
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      words_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      words_q <= words_d;
      req_q   <= req_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Run parameters are always loaded on an accepted start, so they need no reset.
  always_ff @(posedge clk) begin
    src_q     <= src_d;
    dst_q     <= dst_d;
    len_q     <= len_d;
    src_inc_q <= src_inc_d;
    dst_inc_q <= dst_inc_d;
  end

  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == FIN);
  assign err_o        = err_q;
  assign words_done_o = words_q;
  assign host_req_o   = req_q;
  assign host_addr_o  = addr_q;
  assign host_we_o    = we_q;
  assign host_be_o    = be_q;
  assign host_wdata_o = wdata_q;

endmodule

// File: doc/accel_host_dma.md
Name: accel_host_dma

Overview:
- Bus-initiator (host-side) block for the LSTM accelerator subsystem. It is the other end of the device-side request/grant/rvalid protocol used by the accelerator's register port.
- Performs a programmed run of 32-bit word copies: read from a source address (data RAM holding weights, x_t, biases, h_t), then write to a destination address (accelerator data register).
- Replaces per-word CPU stores. Sits between a small CSR front end (start/len/address) and the system bus host port.

Parameters:
- BusWidth, 32, data/address width of the host port; only 32 is supported.
- CountWidth, 16, width of the word-count input and the internal counter.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- start_i  input  1  one-cycle pulse; launches a run when idle
- src_addr_i  input  32  first source word address; bits [1:0] ignored (forced 0)
- dst_addr_i  input  32  first destination word address; bits [1:0] ignored
- len_i  input  CountWidth  number of words to copy
- src_inc_i  input  1  1: source +4 per word; 0: fixed address
- dst_inc_i  input  1  1: destination +4 per word; 0: fixed (streaming into one accel register)
- poll_addr_i  input  32  status address polled before each write (optional feature only)
- busy_o  output  1  high from the accepted start until done
- done_o  output  1  one-cycle pulse at end of run (success or error)
- err_o  output  1  sticky error flag; cleared by the next accepted start
- words_done_o  output  CountWidth  words fully written in current/last run
- host_req_o  output  1  bus request
- host_addr_o  output  BusWidth  bus address
- host_we_o  output  1  write enable
- host_be_o  output  BusWidth/8  byte enables; always all-ones when req is high
- host_wdata_o  output  BusWidth  write data
- host_gnt_i  input  1  grant; the request is accepted on a cycle with req&gnt
- host_rvalid_i  input  1  response valid, at least 1 cycle after grant
- host_rdata_i  input  BusWidth  read data, valid with rvalid
- host_err_i  input  1  bus error, valid with rvalid

Behaviour:
- Reset: state IDLE. Outputs busy_o, done_o, err_o, host_req_o, host_we_o = 0. words_done_o, host_addr_o, host_wdata_o = 0. host_be_o = 0.
- Protocol:
  - At most one outstanding transaction.
  - req, addr, we, be and wdata are registered and held stable from req rising until the grant cycle.
  - req drops in the cycle after req&gnt.
  - No new request is issued until rvalid for the previous one.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN.
- IDLE:
  - start_i with len_i != 0: latch addresses, inc flags and len; clear err_o and words_done_o; busy_o=1; go RD_REQ.
  - start_i with len_i == 0: busy_o=1 for one cycle, then FIN. No bus traffic.
- RD_REQ:
  - Drive req=1, we=0, addr=src.
  - On gnt, go RD_WAIT.
- RD_WAIT:
  - On rvalid, capture rdata into the data register.
  - host_err_i=1: set err_o, go FIN.
  - Otherwise go WR_REQ.
- WR_REQ:
  - Drive req=1, we=1, addr=dst, wdata=captured word.
  - On gnt, go WR_WAIT.
- WR_WAIT:
  - On rvalid with err: set err_o, go FIN.
  - Otherwise:
    - words_done+1;
    - src+=4 if src_inc;
    - dst+=4 if dst_inc;
    - if words_done+1 == len, go FIN, else go RD_REQ.
- FIN: done_o=1 for exactly one cycle; busy_o=0 from the next cycle; go IDLE.
- Address arithmetic is modulo 2^32: 0xFFFFFFFC + 4 wraps to 0x00000000 without error.
- start_i while busy_o=1 is ignored; the run continues unchanged.
- rvalid/err arriving in IDLE or in any *_REQ state is ignored.
- rst asserted mid-run:
  - next cycle the block is in reset state and req=0;
  - a late rvalid after reset is ignored;
  - no done_o pulse is produced.
- Back-to-back: start_i in the same cycle as done_o is ignored. A start in the IDLE cycle after FIN is accepted.

Optional Feature:
- Macro ACCEL_DMA_POLL_EN.
- Defined:
  - Adds state POLL between RD_WAIT and WR_REQ.
  - POLL issues a read to poll_addr_i and waits for rvalid.
  - rdata[0]=1: go WR_REQ. rdata[0]=0: reissue the poll read (matches accelerator w_valid handshake).
  - err on the poll read: set err_o, go FIN.
- Not defined: poll_addr_i is unused, and RD_WAIT goes directly to WR_REQ.

Test Plan:
- len=3, src=0x00100000 (inc), dst=0x80005004 (no inc), RAM words 0x11,0x22,0x33, gnt same cycle, rvalid +1 -> three reads at 0x00100000/04/08; three writes to 0x80005004 with data 0x11,0x22,0x33; be=4'hF; done_o one pulse; words_done_o=3; err_o=0.
- len=0 start -> no host_req_o; busy_o high 1 cycle; done_o pulse; words_done_o=0.
- Random gnt stalls (0-5 cycles) and rvalid delay (1-4 cycles), len=8 -> addr/wdata/we stable while req&!gnt; one outstanding transaction; 8 correct writes.
- len=4, host_err_i on the 2nd read -> err_o=1; words_done_o=1; done_o pulse; no further requests; next start clears err_o.
- src=0xFFFFFFFC inc, len=2 -> reads at 0xFFFFFFFC then 0x00000000; start_i pulsed mid-run has no effect.
- With ACCEL_DMA_POLL_EN, poll returns 0,0,1 -> three poll reads before each write; rst pulsed mid-poll -> req=0 next cycle, busy_o=0, no done_o.
